bcd_down_counter: RTL and testbench



---
 rtl/bcd_down_counter.sv | 47 ++++
 tb/tb_bcd_down_counter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/bcd_down_counter.sv
// Single-digit BCD down counter (9..0, wrap to 9) with count enable and zero flag.
// Define BCD_DOWN_BORROW_EN to add the cascade borrow output.
module bcd_down_counter #(
    parameter logic [3:0] RESET_VALUE = 4'd9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sel,
    output logic [3:0] q,
    output logic       zero
`ifdef BCD_DOWN_BORROW_EN
    ,
    output logic       borrow
`endif
);

    // An out-of-range reset value would start the digit in a non-BCD state.
    localparam logic [3:0] LOAD_VALUE = (RESET_VALUE > 4'd9) ? 4'd9 : RESET_VALUE;

    logic [3:0] count;
    logic [3:0] countNext;

    // Zero wraps to nine, and any non-BCD code recovers to nine as well.
    always_comb begin
        countNext = 4'd9;
        if ((count != 4'd0) && (count <= 4'd9)) begin
            countNext = count - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= LOAD_VALUE;
        end else if (sel) begin
            count <= countNext;
        end
    end

    assign q    = count;
    assign zero = (count == 4'd0);

`ifdef BCD_DOWN_BORROW_EN
    // Enables the next more-significant digit on the edge where this one wraps.
    assign borrow = zero && sel && !rst;
`endif

endmodule

// File: tb/tb_bcd_down_counter.sv
// Directed self-checking bench for bcd_down_counter; covers borrow when
// BCD_DOWN_BORROW_EN is defined.
module tb_bcd_down_counter;

    logic       clk;
    logic       rst;
    logic       sel;
    logic [3:0] q;
    logic       zero;
`ifdef BCD_DOWN_BORROW_EN
    logic       borrow;
`endif

    int checkCount;
    int failCount;

    bcd_down_counter #(.RESET_VALUE(4'd9)) dut (
        .clk   (clk),
        .rst   (rst),
        .sel   (sel),
        .q     (q),
        .zero  (zero)
`ifdef BCD_DOWN_BORROW_EN
        ,
        .borrow(borrow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: actual=%0d required=%0d", tag, observed, expected);
        end
    endtask

    // Drive inputs on the falling edge, then let n rising edges pass and settle.
    task automatic applyStimulus(input logic rstV, input logic selV, input int n);
        @(negedge clk);
        rst = rstV;
        sel = selV;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkState(input string tag, input logic [3:0] expQ);
        checkOutput({tag, "_q"}, {4'd0, q}, {4'd0, expQ});
        checkOutput({tag, "_zero"}, {7'd0, zero}, {7'd0, (expQ == 4'd0)});
    endtask

    logic [3:0] countdown [10];

    initial begin
        checkCount = 0;
        failCount  = 0;
        rst = 1'b1;
        sel = 1'b1;
        countdown = '{4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd9};

        // Reset with sel high, then hold with sel low.
        applyStimulus(1'b1, 1'b1, 1);
        checkState("reset", 4'd9);
        applyStimulus(1'b0, 1'b0, 3);
        checkState("reset_hold", 4'd9);

        // Full countdown with wrap.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b1, 1);
            checkState($sformatf("count%0d", i), countdown[i]);
        end

        // Hold at 6, then one more enabled edge.
        applyStimulus(1'b0, 1'b1, 3);
        checkState("to6", 4'd6);
        applyStimulus(1'b0, 1'b0, 4);
        checkState("hold6", 4'd6);
        applyStimulus(1'b0, 1'b1, 1);
        checkState("after_hold", 4'd5);

        // Reset beats count at q=3.
        applyStimulus(1'b0, 1'b1, 2);
        checkState("to3", 4'd3);
        applyStimulus(1'b1, 1'b1, 1);
        checkState("rst_prio", 4'd9);
        applyStimulus(1'b0, 1'b1, 1);
        checkState("rst_resume", 4'd8);

        // Illegal state recovery.
        @(negedge clk);
        sel = 1'b1;
        force dut.count = 4'd12;
        #1;
        release dut.count;
        @(posedge clk);
        #1;
        checkState("illegal12", 4'd9);

        @(negedge clk);
        sel = 1'b0;
        force dut.count = 4'd14;
        #1;
        release dut.count;
        @(posedge clk);
        #1;
        checkState("illegal14_hold", 4'd14);
        applyStimulus(1'b0, 1'b1, 1);
        checkState("illegal14_recover", 4'd9);

        // Borrow around the 0 -> 9 wrap.
        applyStimulus(1'b0, 1'b1, 9);
        checkState("to0_a", 4'd0);
`ifdef BCD_DOWN_BORROW_EN
        checkOutput("borrow_pre_wrap", {7'd0, borrow}, 8'd1);
`endif
        applyStimulus(1'b0, 1'b1, 1);
        checkState("wrap", 4'd9);
`ifdef BCD_DOWN_BORROW_EN
        checkOutput("borrow_post_wrap", {7'd0, borrow}, 8'd0);
`endif
        applyStimulus(1'b0, 1'b1, 9);
        checkState("to0_b", 4'd0);
        applyStimulus(1'b0, 1'b0, 0);
        #1;
`ifdef BCD_DOWN_BORROW_EN
        checkOutput("borrow_sel0", {7'd0, borrow}, 8'd0);
`endif
        applyStimulus(1'b0, 1'b0, 1);
        checkState("hold0", 4'd0);
        applyStimulus(1'b1, 1'b1, 0);
        #1;
`ifdef BCD_DOWN_BORROW_EN
        checkOutput("borrow_rst", {7'd0, borrow}, 8'd0);
`endif
        checkState("pre_rst_edge", 4'd0);
        applyStimulus(1'b1, 1'b1, 1);
        checkState("final_rst", 4'd9);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
